bus_arbiter_rr: RTL and testbench

// - Next-generation bus generator/arbiter: moves packets between DRVS driver-side FIFOs over one shared bus.
// - Selects a pending source by round-robin or fixed priority and pops one packet from it.
// - Pushes the packet to the addressed destination, or to every driver except the source on broadcast.
// - New over the current bus driver: per-destination backpressure (full), bounded-wait timeout, and drop/delivery counters.

---
 rtl/bus_arb_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/bus_arbiter_rr.sv | 134 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and destination decode for the round-robin bus arbiter.
package bus_arb_pkg;

  localparam int MAX_DRVRS = 32;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DELIVER,
    DROP
  } arb_state_e;

  typedef struct packed {
    logic                 invalid;
    logic [MAX_DRVRS-1:0] mask;
  } dest_dec_t;

  // Broadcast reaches every existing driver except the source; a packet
  // addressed to its own source or to a non-existent driver is invalid.
  function automatic dest_dec_t dest_decode(input logic [31:0] dest,
                                            input logic [4:0]  src,
                                            input int          n_drv,
                                            input logic [31:0] bcast);
    dest_dec_t res;
    res.invalid = 1'b0;
    res.mask    = '0;
    if (dest == bcast) begin
      for (int i = 0; i < MAX_DRVRS; i++) begin
        res.mask[i] = (i < n_drv) && (i != int'(src));
      end
    end else if ((dest < 32'(n_drv)) && (dest != 32'(src))) begin
      res.mask[dest[4:0]] = 1'b1;
    end else begin
      res.invalid = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Requester select: round-robin from a registered pointer, or fixed
// priority (lowest index wins) when PRIO_MODE is set.
module rr_arbiter #(
  parameter int N         = 8,
  parameter int PRIO_MODE = 0,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N-1:0]     req_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_req_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               base;
  int               cand;

  always_comb begin
    grant_idx_o = '0;
    found       = 1'b0;
    base        = (PRIO_MODE != 0) ? 0 : int'(ptr_q);
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = (base + k) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        grant_idx_o = IDX_W'(cand);
      end
    end
  end

  assign any_req_o = |req_i;

  // The pointer moves just past the last winner so it gets lowest priority next.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (upd_i && (PRIO_MODE == 0)) begin
      ptr_q <= (upd_idx_i == IDX_W'(N - 1)) ? '0 : upd_idx_i + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared-bus packet mover: pops one packet from a selected driver FIFO and
// pushes it to its destination(s), with backpressure timeout and statistics.
//   state   | meaning
//   IDLE    | waiting for any pending source; latches the winner
//   POP     | pop strobe to winner, packet captured and destination decoded
//   DELIVER | push as soon as all targeted destinations are not full
//   DROP    | count one dropped packet (invalid destination or timeout)
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int               pckg_sz   = 16,
  parameter int               drvrs     = 8,
  parameter int               ID_W      = 8,
  parameter logic [ID_W-1:0]  BROADCAST = {ID_W{1'b1}},
  parameter int               PRIO_MODE = 0,
  parameter int               TIMEOUT   = 64,
  parameter int               CNT_W     = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [drvrs-1:0]               pndng_i,
  input  logic [drvrs-1:0][pckg_sz-1:0]  d_pop_i,
  output logic [drvrs-1:0]               pop_o,
  input  logic [drvrs-1:0]               full_i,
  output logic [drvrs-1:0]               push_o,
  output logic [drvrs-1:0][pckg_sz-1:0]  d_push_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               deliv_cnt_o,
  output logic [CNT_W-1:0]               drop_cnt_o
);

  localparam int IDX_W = $clog2(drvrs);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   win_q;
  logic [pckg_sz-1:0] pkt_q;
  logic [pckg_sz-1:0] d_push_q;
  logic [drvrs-1:0]   mask_q;
  logic [drvrs-1:0]   pop_q;
  logic [TMO_W-1:0]   wait_q;
  logic [CNT_W-1:0]   deliv_q;
  logic [CNT_W-1:0]   drop_q;

  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  dest_dec_t          dec;
  logic               dec_unused;
  logic               blocked;
  logic               deliver_now;

  rr_arbiter #(
    .N         (drvrs),
    .PRIO_MODE (PRIO_MODE),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (pndng_i),
    .upd_i       (state_q == POP),
    .upd_idx_i   (win_q),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  assign dec = dest_decode(32'(d_pop_i[win_q][pckg_sz-1 -: ID_W]), 5'(win_q),
                           drvrs, 32'(BROADCAST));
  assign dec_unused = |(dec.mask >> drvrs);

  assign blocked     = |(mask_q & full_i);
  assign deliver_now = (state_q == DELIVER) && !blocked;

  // Push is combinational on full so delivery happens in the first free cycle.
  assign push_o = deliver_now ? mask_q : '0;

  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      d_push_o[i] = deliver_now ? pkt_q : d_push_q;
    end
  end

  assign pop_o       = pop_q;
  assign busy_o      = (state_q != IDLE);
  assign deliv_cnt_o = deliv_q;
  assign drop_cnt_o  = drop_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      win_q    <= '0;
      pkt_q    <= '0;
      d_push_q <= '0;
      mask_q   <= '0;
      pop_q    <= '0;
      wait_q   <= '0;
      deliv_q  <= '0;
      drop_q   <= '0;
    end else begin
      pop_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q   <= grant_idx;
            pop_q   <= {{(drvrs-1){1'b0}}, 1'b1} << grant_idx;
            state_q <= POP;
          end
        end
        POP: begin
          pkt_q   <= d_pop_i[win_q];
          mask_q  <= dec.mask[drvrs-1:0];
          wait_q  <= TMO_W'(TIMEOUT - 1);
          state_q <= dec.invalid ? DROP : DELIVER;
        end
        DELIVER: begin
          if (!blocked) begin
            d_push_q <= pkt_q;
            if (deliv_q != '1) deliv_q <= deliv_q + CNT_W'(1);
            state_q  <= IDLE;
          end else if (wait_q == '0) begin
            state_q <= DROP;
          end else begin
            wait_q <= wait_q - TMO_W'(1);
          end
        end
        DROP: begin
          if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scenario bench for bus_arbiter_rr: expected pushes are queued at stimulus
// time and compared when the arbiter delivers (or drops) the packet.
module tb_bus_arbiter_rr;

  typedef struct packed {
    logic [7:0]  mask;
    logic [15:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [7:0]       pndng_i, full_i, pop_o, push_o;
  logic [7:0][15:0] d_pop_i, d_push_o;
  logic             busy_o;
  logic [15:0]      deliv_cnt_o, drop_cnt_o;

  logic [7:0]       pndng2, full2, pop2, push2;
  logic [7:0][15:0] d_pop2, d_push2;
  logic             busy2;
  logic [15:0]      deliv2, drop2;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_deliv = 0;
  int          exp_drop  = 0;
  logic [15:0] last_data = '0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  bus_arbiter_rr #(.pckg_sz(16), .drvrs(8), .ID_W(8), .BROADCAST(8'hFF),
                   .PRIO_MODE(0), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .pndng_i(pndng_i), .d_pop_i(d_pop_i),
    .pop_o(pop_o), .full_i(full_i), .push_o(push_o), .d_push_o(d_push_o),
    .busy_o(busy_o), .deliv_cnt_o(deliv_cnt_o), .drop_cnt_o(drop_cnt_o));

  bus_arbiter_rr #(.pckg_sz(16), .drvrs(8), .ID_W(8), .BROADCAST(8'hFF),
                   .PRIO_MODE(1), .TIMEOUT(64), .CNT_W(16)) dut_prio (
    .clk_i(clk), .reset_i(reset_i), .pndng_i(pndng2), .d_pop_i(d_pop2),
    .pop_o(pop2), .full_i(full2), .push_o(push2), .d_push_o(d_push2),
    .busy_o(busy2), .deliv_cnt_o(deliv2), .drop_cnt_o(drop2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise pndng for one source until the pop strobe is seen, then drop it.
  task automatic issue(input int src, input logic [15:0] pkt,
                       output logic [7:0] popv, output int pop_k);
    popv  = '0;
    pop_k = -1;
    pndng_i[src] = 1'b1;
    d_pop_i[src] = pkt;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pop_o !== 8'h00) begin
        popv  = pop_o;
        pop_k = k;
        cyc();
        break;
      end
      cyc();
    end
    pndng_i[src] = 1'b0;
  endtask

  // Follow the transaction until the arbiter is idle, recording any push.
  task automatic watch(input int budget, output logic [7:0] pushv,
                       output logic [7:0][15:0] pdata,
                       output int push_k, output int idle_k);
    pushv  = '0;
    pdata  = '0;
    push_k = -1;
    idle_k = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (push_o !== 8'h00 && push_k < 0) begin
        pushv  = push_o;
        pdata  = d_push_o;
        push_k = k;
      end
      if (busy_o === 1'b0) begin
        idle_k = k;
        cyc();
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [7:0] acc_pop, acc_push;
    logic       acc_busy;
    acc_pop = '0; acc_push = '0; acc_busy = 1'b0;
    reset_i = 1'b1;
    repeat (3) cyc();
    reset_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc_pop  = acc_pop | pop_o;
      acc_push = acc_push | push_o;
      acc_busy = acc_busy | busy_o;
      cyc();
    end
    n_tests++; if (acc_pop !== 8'h00) begin n_fail++; $display("FAIL reset_pop: got %h want 00", acc_pop); end
    n_tests++; if (acc_push !== 8'h00) begin n_fail++; $display("FAIL reset_push: got %h want 00", acc_push); end
    n_tests++; if (acc_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", acc_busy); end
    n_tests++; if (deliv_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_deliv: got %0d want 0", deliv_cnt_o); end
    n_tests++; if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
    n_tests++; if (d_push_o !== '0) begin n_fail++; $display("FAIL reset_dpush: got %h want 0", d_push_o); end
  endtask

  task automatic test_unicast();
    logic [7:0]       popv, pushv;
    logic [7:0][15:0] pdata;
    int               pk, push_k, idle_k;
    exp_t             e;
    sb.push_back('{mask: 8'b0010_0000, data: 16'h05AB});
    issue(2, 16'h05AB, popv, pk);
    n_tests++; if (popv !== 8'h04 || pk != 1) begin n_fail++; $display("FAIL uni_pop: got %h@%0d want 04@1", popv, pk); end
    watch(10, pushv, pdata, push_k, idle_k);
    e = sb.pop_front();
    exp_deliv++;
    last_data = e.data;
    n_tests++; if (pushv !== e.mask || push_k != 0) begin n_fail++; $display("FAIL uni_push: got %b@%0d want %b@0", pushv, push_k, e.mask); end
    n_tests++; if (pdata[5] !== e.data) begin n_fail++; $display("FAIL uni_data: got %h want %h", pdata[5], e.data); end
    n_tests++; if (idle_k != 1) begin n_fail++; $display("FAIL uni_idle: got %0d want 1", idle_k); end
    n_tests++; if (deliv_cnt_o !== 16'(exp_deliv)) begin n_fail++; $display("FAIL uni_deliv: got %0d want %0d", deliv_cnt_o, exp_deliv); end
    n_tests++; if (d_push_o[5] !== last_data || push_o !== 8'h00) begin n_fail++; $display("FAIL uni_hold: got %h want %h", d_push_o[5], last_data); end
  endtask

  task automatic test_broadcast();
    logic [7:0]       popv, pushv;
    logic [7:0][15:0] pdata, want;
    int               pk, push_k, idle_k;
    exp_t             e;
    sb.push_back('{mask: 8'b1111_0111, data: 16'hFF12});
    issue(3, 16'hFF12, popv, pk);
    n_tests++; if (popv !== 8'h08) begin n_fail++; $display("FAIL bc_pop: got %h want 08", popv); end
    watch(10, pushv, pdata, push_k, idle_k);
    e = sb.pop_front();
    want = {8{e.data}};
    exp_deliv++;
    last_data = e.data;
    n_tests++; if (pushv !== e.mask || push_k != 0) begin n_fail++; $display("FAIL bc_push: got %b@%0d want %b@0", pushv, push_k, e.mask); end
    n_tests++; if (pdata !== want) begin n_fail++; $display("FAIL bc_data: got %h want %h", pdata, want); end
    n_tests++; if (deliv_cnt_o !== 16'(exp_deliv) || drop_cnt_o !== 16'(exp_drop)) begin n_fail++; $display("FAIL bc_cnt: got %0d/%0d want %0d/%0d", deliv_cnt_o, drop_cnt_o, exp_deliv, exp_drop); end
  endtask

  task automatic test_round_robin();
    logic [7:0]       rrq[$];
    logic [7:0]       expv, pushv;
    logic [7:0][15:0] pdata;
    int               prev, npop, npop2, bad2, overlap, push_k, idle_k;
    reset_i = 1'b1;
    cyc(); cyc();
    reset_i = 1'b0;
    exp_deliv = 0; exp_drop = 0; last_data = '0;
    for (int i = 0; i < 8; i++) begin
      d_pop_i[i] = {8'((i + 1) % 8), 8'(i)};
      d_pop2[i]  = {8'((i + 1) % 8), 8'(i)};
    end
    for (int j = 0; j < 9; j++) rrq.push_back(8'h01 << (j % 8));
    prev = -1; npop = 0; npop2 = 0; bad2 = 0; overlap = 0;
    pndng_i = 8'hFF;
    pndng2  = 8'hFF;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (pop_o !== 8'h00) begin
        npop++;
        expv = (rrq.size() > 0) ? rrq.pop_front() : 8'h00;
        n_tests++; if (pop_o !== expv) begin n_fail++; $display("FAIL rr_order: got %b want %b", pop_o, expv); end
        if (prev >= 0) begin
          n_tests++; if (k - prev != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d want 3", k - prev); end
        end
        prev = k;
        if (push_o !== 8'h00) overlap++;
      end
      if (pop2 !== 8'h00) begin
        npop2++;
        if (pop2 !== 8'h01) bad2++;
      end
      cyc();
    end
    pndng_i = '0;
    pndng2  = '0;
    watch(10, pushv, pdata, push_k, idle_k);
    exp_deliv = 9;
    last_data = 16'h0100;
    n_tests++; if (npop != 9) begin n_fail++; $display("FAIL rr_npop: got %0d want 9", npop); end
    n_tests++; if (overlap != 0) begin n_fail++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
    n_tests++; if (npop2 != 9 || bad2 != 0) begin n_fail++; $display("FAIL prio_pop: got %0d pops %0d not-zero want 9/0", npop2, bad2); end
    n_tests++; if (deliv_cnt_o !== 16'(exp_deliv)) begin n_fail++; $display("FAIL rr_deliv: got %0d want %0d", deliv_cnt_o, exp_deliv); end
    n_tests++; if (d_push_o[0] !== last_data) begin n_fail++; $display("FAIL rr_hold: got %h want %h", d_push_o[0], last_data); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  popv, pushv;
    logic [15:0] pdata0;
    int          pk, push_k;
    exp_t        e;
    full_i[4] = 1'b1;
    sb.push_back('{mask: 8'h10, data: 16'h043C});
    issue(1, 16'h043C, popv, pk);
    n_tests++; if (popv !== 8'h02) begin n_fail++; $display("FAIL bp_pop: got %h want 02", popv); end
    pushv = '0; pdata0 = '0; push_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) full_i[4] = 1'b0;
      @(negedge clk);
      if (push_o !== 8'h00) begin
        pushv  = push_o;
        pdata0 = d_push_o[4];
        push_k = k;
        cyc();
        break;
      end
      cyc();
    end
    full_i[4] = 1'b0;
    e = sb.pop_front();
    exp_deliv++;
    last_data = e.data;
    n_tests++; if (push_k != 5 || pushv !== e.mask) begin n_fail++; $display("FAIL bp_push: got %b@%0d want %b@5", pushv, push_k, e.mask); end
    n_tests++; if (pdata0 !== e.data) begin n_fail++; $display("FAIL bp_data: got %h want %h", pdata0, e.data); end
    cyc();
    n_tests++; if (deliv_cnt_o !== 16'(exp_deliv)) begin n_fail++; $display("FAIL bp_deliv: got %0d want %0d", deliv_cnt_o, exp_deliv); end
  endtask

  task automatic test_timeout();
    logic [7:0]       popv, pushv;
    logic [7:0][15:0] pdata;
    int               pk, push_k, idle_k;
    exp_t             e;
    full_i[4] = 1'b1;
    sb.push_back('{mask: 8'h00, data: 16'h04D2});
    issue(1, 16'h04D2, popv, pk);
    watch(100, pushv, pdata, push_k, idle_k);
    full_i[4] = 1'b0;
    e = sb.pop_front();
    if (e.mask == 8'h00) exp_drop++;
    n_tests++; if (push_k != -1) begin n_fail++; $display("FAIL tmo_push: got push %b@%0d want none", pushv, push_k); end
    n_tests++; if (idle_k != 65) begin n_fail++; $display("FAIL tmo_len: got %0d want 65", idle_k); end
    n_tests++; if (drop_cnt_o !== 16'(exp_drop) || deliv_cnt_o !== 16'(exp_deliv)) begin n_fail++; $display("FAIL tmo_cnt: got %0d/%0d want %0d/%0d", drop_cnt_o, deliv_cnt_o, exp_drop, exp_deliv); end
    n_tests++; if (d_push_o[4] !== last_data) begin n_fail++; $display("FAIL tmo_hold: got %h want %h", d_push_o[4], last_data); end
  endtask

  task automatic test_invalid();
    int               srcs[6]  = '{0, 5, 6, 6, 7, 0};
    logic [15:0]      pkts[6]  = '{16'h0955, 16'h0577, 16'h0801, 16'h07AA, 16'hFE00, 16'hFF00};
    logic [7:0]       masks[6] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'hFE};
    logic [7:0]       popv, pushv;
    logic [7:0][15:0] pdata;
    int               pk, push_k, idle_k;
    exp_t             e;
    for (int c = 0; c < 6; c++) begin
      sb.push_back('{mask: masks[c], data: pkts[c]});
      issue(srcs[c], pkts[c], popv, pk);
      n_tests++; if (popv !== (8'h01 << srcs[c])) begin n_fail++; $display("FAIL inv_pop[%0d]: got %h want %h", c, popv, 8'h01 << srcs[c]); end
      watch(20, pushv, pdata, push_k, idle_k);
      e = sb.pop_front();
      if (e.mask == 8'h00) begin
        exp_drop++;
        n_tests++; if (push_k != -1) begin n_fail++; $display("FAIL inv_nopush[%0d]: got %b want none", c, pushv); end
      end else begin
        exp_deliv++;
        last_data = e.data;
        n_tests++; if (pushv !== e.mask || pdata[7] !== e.data || push_k != 0) begin n_fail++; $display("FAIL inv_push[%0d]: got %b/%h@%0d want %b/%h@0", c, pushv, pdata[7], push_k, e.mask, e.data); end
      end
      n_tests++; if (idle_k != 1) begin n_fail++; $display("FAIL inv_idle[%0d]: got %0d want 1", c, idle_k); end
      n_tests++; if (drop_cnt_o !== 16'(exp_drop) || deliv_cnt_o !== 16'(exp_deliv)) begin n_fail++; $display("FAIL inv_cnt[%0d]: got %0d/%0d want %0d/%0d", c, drop_cnt_o, deliv_cnt_o, exp_drop, exp_deliv); end
      n_tests++; if (d_push_o[1] !== last_data) begin n_fail++; $display("FAIL inv_hold[%0d]: got %h want %h", c, d_push_o[1], last_data); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] popv, acc_push;
    logic       acc_busy;
    int         pk;
    full_i[4] = 1'b1;
    issue(2, 16'h04C3, popv, pk);
    repeat (3) cyc();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    full_i[4] = 1'b0;
    exp_deliv = 0; exp_drop = 0; last_data = '0;
    acc_push = '0; acc_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc_push = acc_push | push_o;
      acc_busy = acc_busy | busy_o;
      cyc();
    end
    n_tests++; if (acc_push !== 8'h00) begin n_fail++; $display("FAIL rmid_push: got %b want 00", acc_push); end
    n_tests++; if (acc_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", acc_busy); end
    n_tests++; if (deliv_cnt_o !== 16'(exp_deliv) || drop_cnt_o !== 16'(exp_drop)) begin n_fail++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", deliv_cnt_o, drop_cnt_o); end
    n_tests++; if (d_push_o[0] !== last_data) begin n_fail++; $display("FAIL rmid_dpush: got %h want %h", d_push_o[0], last_data); end
  endtask

  initial begin
    reset_i = 1'b1;
    pndng_i = '0; full_i = '0; d_pop_i = '0;
    pndng2  = '0; full2  = '0; d_pop2  = '0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_invalid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
